// File: rtl/dds_pkg.sv
// Shared DDS control constants and the command-parser FSM state encoding.
// The DDS core decodes control with the same command codes.
package dds_pkg;

  localparam logic [7:0] HDR_BYTE = 8'h55;
  localparam logic [7:0] CMD_SEL  = 8'h01;
  localparam logic [7:0] CMD_FREQ = 8'h02;
  localparam logic [7:0] CMD_RUN  = 8'h03;

  typedef enum logic [1:0] {
    ST_HDR = 2'd0,
    ST_CMD = 2'd1,
    ST_VAL = 2'd2,
    ST_CHK = 2'd3
  } state_t;

endpackage

// File: rtl/frame_timeout.sv
// Inter-byte gap counter: tc is high, same cycle, when the counter sits on its last value with no clear.
// Counter saturates rather than wrapping; clr always wins over counting and over tc.
module frame_timeout #(
  parameter int TIMEOUT_CYC = 500_000
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam int CW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT_CYC - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  assign tc = en && !clr && (cnt_q == CNT_MAX);

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/dds_cmd_parser.sv
// Frames UART bytes as 55/CMD/VAL/CHK and applies valid commands to registered DDS controls.
// Result and cmd_ok/cmd_err appear one cycle after the CHK strobe; no backpressure, every strobe is consumed.
module dds_cmd_parser #(
  parameter int         TIMEOUT_CYC = 500_000,
  parameter logic [7:0] FREQ_INIT   = 8'd1
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic [7:0] rx_data,
  input  logic       rx_flag,
  output logic       sel,
  output logic       flag,
  output logic [7:0] freq,
  output logic       cmd_ok,
  output logic       cmd_err
);

  import dds_pkg::*;

  state_t     state_q, state_d;
  logic [7:0] cmd_q, cmd_d;
  logic [7:0] val_q, val_d;
  logic       sel_q, sel_d;
  logic       flag_q, flag_d;
  logic [7:0] freq_q, freq_d;
  logic       ok_q, ok_d;
  logic       err_q, err_d;
  logic       tmo_tc;
  logic       frame_ok;

  // Counter is held cleared while hunting for a header.
  frame_timeout #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_timeout (
    .sys_clk  (sys_clk),
    .sys_rst_n(sys_rst_n),
    .clr      (rx_flag || (state_q == ST_HDR)),
    .en       (state_q != ST_HDR),
    .tc       (tmo_tc)
  );

  assign frame_ok = (rx_data == (cmd_q ^ val_q)) &&
                    ((cmd_q == CMD_SEL) || (cmd_q == CMD_RUN) ||
                     ((cmd_q == CMD_FREQ) && (val_q != 8'h00)));

  always_comb begin
    state_d = state_q;
    cmd_d   = cmd_q;
    val_d   = val_q;
    sel_d   = sel_q;
    flag_d  = flag_q;
    freq_d  = freq_q;
    ok_d    = 1'b0;
    err_d   = 1'b0;
    if (tmo_tc) begin
      state_d = ST_HDR;
      err_d   = 1'b1;
    end else if (rx_flag) begin
      case (state_q)
        ST_HDR: begin
          if (rx_data == HDR_BYTE) state_d = ST_CMD;
        end
        ST_CMD: begin
          cmd_d   = rx_data;
          state_d = ST_VAL;
        end
        ST_VAL: begin
          val_d   = rx_data;
          state_d = ST_CHK;
        end
        ST_CHK: begin
          state_d = ST_HDR;
          if (frame_ok) begin
            ok_d = 1'b1;
            if (cmd_q == CMD_SEL)  sel_d  = val_q[0];
            if (cmd_q == CMD_FREQ) freq_d = val_q;
            if (cmd_q == CMD_RUN)  flag_d = val_q[0];
          end else begin
            err_d = 1'b1;
          end
        end
        default: state_d = ST_HDR;
      endcase
    end
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      state_q <= ST_HDR;
      cmd_q   <= 8'h00;
      val_q   <= 8'h00;
      sel_q   <= 1'b0;
      flag_q  <= 1'b0;
      freq_q  <= FREQ_INIT;
      ok_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      val_q   <= val_d;
      sel_q   <= sel_d;
      flag_q  <= flag_d;
      freq_q  <= freq_d;
      ok_q    <= ok_d;
      err_q   <= err_d;
    end
  end

  assign sel     = sel_q;
  assign flag    = flag_q;
  assign freq    = freq_q;
  assign cmd_ok  = ok_q;
  assign cmd_err = err_q;

endmodule

// File: tb/tb_dds_cmd_parser.sv
// Directed frames against dds_cmd_parser; expected pulses are queued by stimulus and matched by a monitor.
module tb_dds_cmd_parser;

  logic       sys_clk = 1'b0;
  logic       sys_rst_n = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_flag = 1'b0;
  logic       sel, flag, cmd_ok, cmd_err;
  logic [7:0] freq;

  dds_cmd_parser #(
    .TIMEOUT_CYC(8),
    .FREQ_INIT  (8'd1)
  ) dut (
    .sys_clk  (sys_clk),
    .sys_rst_n(sys_rst_n),
    .rx_data  (rx_data),
    .rx_flag  (rx_flag),
    .sel      (sel),
    .flag     (flag),
    .freq     (freq),
    .cmd_ok   (cmd_ok),
    .cmd_err  (cmd_err)
  );

  always #5 sys_clk = ~sys_clk;

  int cyc = 0;
  always @(posedge sys_clk) cyc <= cyc + 1;

  typedef struct {
    logic       is_ok;
    logic       sel;
    logic       flag;
    logic [7:0] freq;
    int         cyc;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every pulse must match the oldest queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge sys_clk);
      #1;
      if (cmd_ok || cmd_err) begin
        chk("ok_err_exclusive", int'(cmd_ok && cmd_err), 0);
        if (exp_q.size() == 0) begin
          chk("unexpected_pulse", {30'd0, cmd_ok, cmd_err}, 0);
        end else begin
          e = exp_q.pop_front();
          chk("pulse_kind_ok", int'(cmd_ok), int'(e.is_ok));
          chk("pulse_cycle", cyc, e.cyc);
          chk("sel", int'(sel), int'(e.sel));
          chk("flag", int'(flag), int'(e.flag));
          chk("freq", int'(freq), int'(e.freq));
        end
      end
    end
  end

  task automatic drive(input logic f, input logic [7:0] d);
    @(negedge sys_clk);
    rx_flag = f;
    rx_data = d;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 8'h00);
  endtask

  task automatic push(input logic ok, input logic s, input logic f, input logic [7:0] fr, input int c);
    exp_t e;
    e.is_ok = ok;
    e.sel   = s;
    e.flag  = f;
    e.freq  = fr;
    e.cyc   = c;
    exp_q.push_back(e);
  endtask

  // Four back-to-back strobes; the pulse is due one cycle after the CHK strobe.
  task automatic frame(input logic [7:0] c, input logic [7:0] v, input logic [7:0] k,
                       input logic ok, input logic s, input logic f, input logic [7:0] fr);
    drive(1'b1, 8'h55);
    drive(1'b1, c);
    drive(1'b1, v);
    drive(1'b1, k);
    push(ok, s, f, fr, cyc + 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    @(negedge sys_clk);
    chk({tag, "_sel"}, int'(sel), 0);
    chk({tag, "_flag"}, int'(flag), 0);
    chk({tag, "_freq"}, int'(freq), 1);
    chk({tag, "_ok"}, int'(cmd_ok), 0);
    chk({tag, "_err"}, int'(cmd_err), 0);
  endtask

  initial begin
    int c;
    idle(3);
    drive(1'b0, 8'h00);
    sys_rst_n = 1'b1;
    check_reset_outputs("reset");
    idle(5);

    frame(8'h02, 8'h40, 8'h42, 1'b1, 1'b0, 1'b0, 8'h40);
    idle(2);
    frame(8'h03, 8'h01, 8'h02, 1'b1, 1'b0, 1'b1, 8'h40);
    idle(2);
    frame(8'h01, 8'h01, 8'h00, 1'b1, 1'b1, 1'b1, 8'h40);
    idle(2);

    frame(8'h02, 8'h40, 8'h43, 1'b0, 1'b1, 1'b1, 8'h40);
    idle(2);
    frame(8'h07, 8'h00, 8'h07, 1'b0, 1'b1, 1'b1, 8'h40);
    idle(2);
    frame(8'h02, 8'h00, 8'h02, 1'b0, 1'b1, 1'b1, 8'h40);
    idle(2);

    // Noise then two frames with no gap, the second header right after CHK.
    drive(1'b1, 8'h12);
    drive(1'b1, 8'hAA);
    frame(8'h02, 8'h10, 8'h12, 1'b1, 1'b1, 1'b1, 8'h10);
    frame(8'h01, 8'h00, 8'h01, 1'b1, 1'b0, 1'b1, 8'h10);
    idle(3);

    // Stall after CMD: 8 idle cycles, error visible the cycle after.
    drive(1'b1, 8'h55);
    drive(1'b1, 8'h02);
    c = cyc;
    push(1'b0, 1'b0, 1'b1, 8'h10, c + 9);
    idle(10);
    drive(1'b1, 8'h40);
    drive(1'b1, 8'h42);
    idle(12);

    // VAL lands on the terminal-count cycle: the byte wins.
    drive(1'b1, 8'h55);
    drive(1'b1, 8'h02);
    idle(7);
    drive(1'b1, 8'h20);
    drive(1'b1, 8'h22);
    push(1'b1, 1'b0, 1'b1, 8'h20, cyc + 1);
    idle(12);

    // Reset mid-frame: silent abort, outputs back to reset values.
    drive(1'b1, 8'h55);
    drive(1'b1, 8'h03);
    drive(1'b0, 8'h00);
    sys_rst_n = 1'b0;
    idle(2);
    sys_rst_n = 1'b1;
    check_reset_outputs("midreset");
    drive(1'b1, 8'h00);
    drive(1'b1, 8'h03);
    frame(8'h02, 8'h33, 8'h31, 1'b1, 1'b0, 1'b0, 8'h33);
    idle(15);

    chk("pending_expectations", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
